serial_io_bridge: RTL and testbench

Byte-stream buffer between the processor's serial IO ports (as wired through data_memory) and the external serial link. Holds two independent first-word-fall-through FIFOs: RX (external link → processor `serial_in`) and TX (processor `serial_out` → external link). Both sides use a valid/ready-style handshake, so the processor can poll availability and issue single-cycle read and write strobes.

---
 rtl/serial_io_bridge.sv | 153 +++++++++++++++
 tb/tb_serial_io_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_io_bridge.sv
// serial_io_bridge: RX and TX byte FIFOs between the processor serial
// ports and the external serial link, with sticky error flags.
//
// serial_fifo ports:
//   clock, reset       : clock, async active-low reset
//   push_i, data_i     : push request and byte
//   pop_i              : pop request
//   head_o             : head byte, 8'h00 when empty
//   valid_o, ready_o   : non-empty, not full
//   count_o            : occupancy 0..DEPTH
//
// serial_io_bridge ports:
//   clock, reset                                     : clock, async active-low reset
//   serial_in, serial_valid_in, serial_rden_out      : processor RX side
//   serial_out, serial_wren_out, serial_ready_in     : processor TX side
//   rx_data, rx_valid, rx_ready                      : link RX side
//   tx_data, tx_valid, tx_ready                      : link TX side
//   rx_count, tx_count                               : FIFO occupancy
//   rx_overrun, rx_underrun, tx_overrun              : sticky error flags

module serial_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic          valid_o,
    output logic          ready_o,
    output logic [AW:0]   count_o
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // Flags come from the registered count only, so a full FIFO
    // refuses a push even when it is popped in the same cycle.
    assign valid_o = (count_q != '0);
    assign ready_o = (count_q != FULL);
    assign count_o = count_q;
    assign head_o  = valid_o ? mem_q[rd_q] : 8'h00;

    assign do_push = push_i && ready_o;
    assign do_pop  = pop_i && valid_o;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        if (do_push && !do_pop) count_d = count_q + ONE;
        if (do_pop && !do_push) count_d = count_q - ONE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

module serial_io_bridge #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [7:0]  serial_in,
    output logic        serial_valid_in,
    input  logic        serial_rden_out,
    input  logic [7:0]  serial_out,
    input  logic        serial_wren_out,
    output logic        serial_ready_in,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [AW:0] rx_count,
    output logic [AW:0] tx_count,
    output logic        rx_overrun,
    output logic        rx_underrun,
    output logic        tx_overrun
);
    logic rx_ov_q, rx_ov_d;
    logic rx_un_q, rx_un_d;
    logic tx_ov_q, tx_ov_d;

    serial_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx (
        .clock   (clock),
        .reset   (reset),
        .push_i  (rx_valid),
        .data_i  (rx_data),
        .pop_i   (serial_rden_out),
        .head_o  (serial_in),
        .valid_o (serial_valid_in),
        .ready_o (rx_ready),
        .count_o (rx_count)
    );

    serial_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx (
        .clock   (clock),
        .reset   (reset),
        .push_i  (serial_wren_out),
        .data_i  (serial_out),
        .pop_i   (tx_ready),
        .head_o  (tx_data),
        .valid_o (tx_valid),
        .ready_o (serial_ready_in),
        .count_o (tx_count)
    );

    assign rx_ov_d = rx_ov_q | (rx_valid && !rx_ready);
    assign rx_un_d = rx_un_q | (serial_rden_out && !serial_valid_in);
    assign tx_ov_d = tx_ov_q | (serial_wren_out && !serial_ready_in);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_ov_q <= 1'b0;
            rx_un_q <= 1'b0;
            tx_ov_q <= 1'b0;
        end else begin
            rx_ov_q <= rx_ov_d;
            rx_un_q <= rx_un_d;
            tx_ov_q <= tx_ov_d;
        end
    end

    assign rx_overrun  = rx_ov_q;
    assign rx_underrun = rx_un_q;
    assign tx_overrun  = tx_ov_q;
endmodule

// File: tb/tb_serial_io_bridge.sv
// tb_serial_io_bridge: scenario tasks plus randomized traffic checked
// against queue-based models of the two FIFOs.

module tb_serial_io_bridge;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] serial_in;
    logic       serial_valid_in;
    logic       serial_rden_out = 1'b0;
    logic [7:0] serial_out = 8'h00;
    logic       serial_wren_out = 1'b0;
    logic       serial_ready_in;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [4:0] rx_count;
    logic [4:0] tx_count;
    logic       rx_overrun;
    logic       rx_underrun;
    logic       tx_overrun;

    int tests = 0;
    int fails = 0;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    bit m_rx_ov, m_rx_un, m_tx_ov;

    always #5 clock = ~clock;

    serial_io_bridge dut (
        .clock           (clock),
        .reset           (reset),
        .serial_in       (serial_in),
        .serial_valid_in (serial_valid_in),
        .serial_rden_out (serial_rden_out),
        .serial_out      (serial_out),
        .serial_wren_out (serial_wren_out),
        .serial_ready_in (serial_ready_in),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .rx_count        (rx_count),
        .tx_count        (tx_count),
        .rx_overrun      (rx_overrun),
        .rx_underrun     (rx_underrun),
        .tx_overrun      (tx_overrun)
    );

    wire [32:0] dut_vec = {serial_in, serial_valid_in, rx_ready, rx_count,
                           tx_data, tx_valid, serial_ready_in, tx_count,
                           rx_overrun, rx_underrun, tx_overrun};

    function automatic logic [32:0] exp_vec();
        logic [7:0] rh, th;
        rh = (rxq.size() != 0) ? rxq[0] : 8'h00;
        th = (txq.size() != 0) ? txq[0] : 8'h00;
        return {rh, rxq.size() != 0, rxq.size() != 16, 5'(rxq.size()),
                th, txq.size() != 0, txq.size() != 16, 5'(txq.size()),
                m_rx_ov, m_rx_un, m_tx_ov};
    endfunction

    // Drives one cycle from a negedge, updates the model at the edge
    // from pre-edge occupancy, and returns at the following negedge.
    task automatic cycle(input bit rv, input logic [7:0] rd, input bit rr,
                         input bit wv, input logic [7:0] wd, input bit tr);
        bit rx_push, rx_pop, tx_push, tx_pop;
        rx_valid = rv; rx_data = rd; serial_rden_out = rr;
        serial_wren_out = wv; serial_out = wd; tx_ready = tr;
        @(posedge clock);
        rx_push = rv && rxq.size() < 16;
        rx_pop  = rr && rxq.size() > 0;
        tx_push = wv && txq.size() < 16;
        tx_pop  = tr && txq.size() > 0;
        if (rv && !rx_push) m_rx_ov = 1;
        if (rr && !rx_pop)  m_rx_un = 1;
        if (wv && !tx_push) m_tx_ov = 1;
        if (rx_pop)  void'(rxq.pop_front());
        if (rx_push) rxq.push_back(rd);
        if (tx_pop)  void'(txq.pop_front());
        if (tx_push) txq.push_back(wd);
        @(negedge clock);
        rx_valid = 0; serial_rden_out = 0;
        serial_wren_out = 0; tx_ready = 0;
    endtask

    task automatic model_clear();
        rxq.delete(); txq.delete();
        m_rx_ov = 0; m_rx_un = 0; m_tx_ov = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 0;
        model_clear();
        @(negedge clock);
        reset = 1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        @(negedge clock);
        tests++;
        if (dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL reset_state got %h exp %h", dut_vec, exp_vec());
        end
        reset = 1;
    endtask

    task automatic test_rx_basic();
        cycle(1, 8'h48, 0, 0, 0, 0);
        tests++;
        if ({serial_valid_in, serial_in, rx_count} !== {1'b1, 8'h48, 5'd1}) begin
            fails++;
            $display("FAIL rx_push got %b/%h/%0d exp 1/48/1",
                     serial_valid_in, serial_in, rx_count);
        end
        cycle(0, 0, 1, 0, 0, 0);
        tests++;
        if ({serial_valid_in, serial_in, rx_count} !== {1'b0, 8'h00, 5'd0}) begin
            fails++;
            $display("FAIL rx_pop got %b/%h/%0d exp 0/00/0",
                     serial_valid_in, serial_in, rx_count);
        end
    endtask

    task automatic test_tx_fill_overrun();
        do_reset();
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, 8'(i), 0);
        tests++;
        if ({tx_count, serial_ready_in, tx_overrun} !== {5'd16, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL tx_full got %0d/%b/%b exp 16/0/0",
                     tx_count, serial_ready_in, tx_overrun);
        end
        cycle(0, 0, 0, 1, 8'hAA, 0);
        tests++;
        if ({tx_count, tx_overrun} !== {5'd16, 1'b1}) begin
            fails++;
            $display("FAIL tx_overrun got %0d/%b exp 16/1", tx_count, tx_overrun);
        end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if ({tx_valid, tx_data} !== {1'b1, 8'(i)}) begin
                fails++;
                $display("FAIL tx_stream[%0d] got %b/%h exp 1/%h",
                         i, tx_valid, tx_data, 8'(i));
            end
            cycle(0, 0, 0, 0, 0, 1);
        end
        tests++;
        if ({tx_valid, tx_data, tx_count} !== {1'b0, 8'h00, 5'd0}) begin
            fails++;
            $display("FAIL tx_drained got %b/%h/%0d exp 0/00/0",
                     tx_valid, tx_data, tx_count);
        end
    endtask

    task automatic test_rx_full_pushpop();
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1, 8'(8'h30 + i), 0, 0, 0, 0);
        cycle(1, 8'h77, 1, 0, 0, 0);
        tests++;
        if ({rx_count, rx_overrun, serial_in} !== {5'd15, 1'b1, 8'h31}) begin
            fails++;
            $display("FAIL rx_full_pushpop got %0d/%b/%h exp 15/1/31",
                     rx_count, rx_overrun, serial_in);
        end
        tests++;
        if (dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL rx_full_model got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        int rd_n;
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 8'(i), 0, 0, 0, 0);
        rd_n = 0;
        for (int i = 5; i < 45; i++) begin
            tests++;
            if ({serial_in, rx_count} !== {8'(rd_n), 5'd5}) begin
                fails++;
                $display("FAIL b2b[%0d] got %h/%0d exp %h/5",
                         i, serial_in, rx_count, 8'(rd_n));
            end
            cycle(1, 8'(i), 1, 0, 0, 0);
            rd_n++;
        end
    endtask

    task automatic test_underrun();
        do_reset();
        cycle(0, 0, 1, 0, 0, 0);
        tests++;
        if ({rx_underrun, rx_count} !== {1'b1, 5'd0}) begin
            fails++;
            $display("FAIL underrun got %b/%0d exp 1/0", rx_underrun, rx_count);
        end
        cycle(1, 8'h21, 0, 0, 0, 0);
        tests++;
        if ({serial_in, rx_count} !== {8'h21, 5'd1}) begin
            fails++;
            $display("FAIL after_underrun got %h/%0d exp 21/1", serial_in, rx_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 7; i++)
            cycle(1, 8'($urandom), 0, 1, 8'($urandom), 0);
        cycle(1, 0, 0, 1, 0, 0);
        tests++;
        if ({rx_count, tx_count} !== {5'd8, 5'd8}) begin
            fails++;
            $display("FAIL prefill got %0d/%0d exp 8/8", rx_count, tx_count);
        end
        #2 reset = 0;
        model_clear();
        #1;
        tests++;
        if (dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL async_reset got %h exp %h", dut_vec, exp_vec());
        end
        @(negedge clock);
        reset = 1;
    endtask

    task automatic test_random();
        int prx, ppop, ptx, ptr;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            case (i / 100)
                0: begin prx = 85; ppop = 20; ptx = 85; ptr = 20; end
                1: begin prx = 20; ppop = 85; ptx = 20; ptr = 85; end
                2: begin prx = 90; ppop = 90; ptx = 90; ptr = 90; end
                3: begin prx = 95; ppop = 5;  ptx = 5;  ptr = 95; end
                4: begin prx = 5;  ppop = 95; ptx = 95; ptr = 5;  end
                default: begin prx = 50; ppop = 50; ptx = 50; ptr = 50; end
            endcase
            cycle($urandom_range(99) < prx, 8'($urandom),
                  $urandom_range(99) < ppop,
                  $urandom_range(99) < ptx, 8'($urandom),
                  $urandom_range(99) < ptr);
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL random[%0d] got %h exp %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_rx_basic();
        test_tx_fill_overrun();
        test_rx_full_pushpop();
        test_back_to_back();
        test_underrun();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
